imem_loader: RTL

- Boot-time writer for the instruction memory write port, which the CPU leaves tied off (readEnable=1, writeEnable=0) and never drives.
- Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive instruction addresses.
- Holds the CPU in reset until a complete frame with a correct checksum has been written, then releases it.
- Sits between the host byte source (UART receiver / testbench) and the CPU/instruction-memory pair.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// big-endian 32-bit words to the instruction memory, holding the CPU in reset until done.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam int unsigned TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [16:0] MAX_W   = 17'(MAX_WORDS);
    localparam logic [31:0] STEP    = 32'(ADDR_STEP);

    logic [2:0]    state;
    logic          armed;
    logic [15:0]   n_words;
    logic [23:0]   asm_word;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic [TW-1:0] to_cnt;

    logic          accept;
    logic          counting;
    logic [15:0]   len_now;
    logic          len_over;
    logic          len_zero;

    // armed keeps in_ready low for the first cycle after reset.
    assign in_ready = armed & ((state == S_LEN_HI) | (state == S_LEN_LO) |
                               (state == S_DATA)   | (state == S_CHECK));
    assign accept   = in_valid & in_ready;
    assign counting = (state == S_LEN_LO) | (state == S_DATA) | (state == S_CHECK);
    assign len_now  = {n_words[15:8], in_data};
    assign len_over = {1'b0, len_now} > MAX_W;
    assign len_zero = (len_now == 16'd0);

    assign done    = (state == S_DONE);
    assign error   = (state == S_ERROR);
    assign cpu_rst = (state != S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_LEN_HI;
            armed        <= 1'b0;
            n_words      <= '0;
            asm_word     <= '0;
            byte_idx     <= '0;
            csum         <= '0;
            to_cnt       <= '0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            imem_we      <= 1'b0;
            words_loaded <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in this
            // block (byte acceptance) intentionally override the timeout path.
            armed   <= 1'b1;
            imem_we <= 1'b0;

            if (counting && !accept) begin
                if (to_cnt == TO_LAST) state <= S_ERROR;
                else                   to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        n_words[15:8] <= in_data;
                        to_cnt        <= '0;
                        state         <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        n_words[7:0] <= in_data;
                        to_cnt       <= '0;
                        if (len_over)      state <= S_ERROR;
                        else if (len_zero) state <= S_CHECK;
                        else               state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        to_cnt   <= '0;
                        csum     <= csum ^ in_data;
                        asm_word <= {asm_word[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {asm_word, in_data};
                            imem_addr    <= BASE_ADDR + {16'h0, words_loaded} * STEP;
                            words_loaded <= words_loaded + 16'd1;
                            if (words_loaded + 16'd1 == n_words) state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        to_cnt <= '0;
                        state  <= (in_data == csum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        state        <= S_LEN_HI;
                        words_loaded <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                        to_cnt       <= '0;
                        imem_addr    <= BASE_ADDR;
                    end
                end
                default: state <= S_LEN_HI;
            endcase
        end
    end

endmodule
